inst_rom_boot: RTL and testbench
================================

Name: inst_rom_boot

Overview:
- Instruction-memory responder for the CPU fetch interface.
- Serves the CPU's `rom_ce`/`rom_addr` requests with 32-bit instruction words on `rom_data`, using a combinational read.
- Before fetching starts, a byte-stream boot loader fills the word array. During that time the block holds the CPU core in reset through `cpu_rst_o`.
- Sits beside the CPU top in the SoC wrapper: it drives the core's `rst` and `rom_data_i`, and receives the core's `rom_addr_o` and `rom_ce_o`.

Parameters:
- ADDR_W, 10, word-address width; array depth = 2**ADDR_W words.
- BOOT_ON_RESET, 1, 1: enter LEN_HI straight out of reset; 0: wait in IDLE for `load_start_i`.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- rom_ce_i  input  1  fetch enable from CPU
- rom_addr_i  input  32  fetch byte address from CPU
- rom_data_o  output  32  instruction word to CPU
- cpu_rst_o  output  1  active-high reset to the CPU core
- load_start_i  input  1  single-cycle pulse; begins (re)load
- load_valid_i  input  1  load byte valid
- load_byte_i  input  8  load byte
- load_ready_o  output  1  block accepts a byte this cycle
- load_busy_o  output  1  loader active
- load_err_o  output  1  sticky error flag; cleared on next start
- words_loaded_o  output  ADDR_W+1  words written by the last load

Behaviour:
- Reset is asynchronous and active-high.
  - Values while `rst` is high: state = LEN_HI if BOOT_ON_RESET else IDLE; `cpu_rst_o`=1; `load_err_o`=0; `words_loaded_o`=0; byte and word counters = 0.
  - The memory array is not reset.
- States: IDLE, LEN_HI, LEN_LO, DATA, [CSUM], RUN, [ERR].
- Byte handshake: a byte transfers on a rising edge where `load_valid_i` && `load_ready_o`. `load_ready_o`=1 only in LEN_HI, LEN_LO, DATA and CSUM.
- Length field: LEN_HI captures N[15:8], then LEN_LO captures N[7:0]. N is the word count.
  - From LEN_LO: if N==0, go to RUN (or CSUM when the option is enabled); otherwise go to DATA.
- DATA state:
  - 2-bit byte counter; bytes are packed big-endian, first byte → bits [31:24].
  - On the 4th byte, write `mem[word_idx]` with the assembled word and increment `word_idx`.
  - After word N-1 is written, leave DATA on the same edge.
  - If `word_idx` >= 2**ADDR_W, the write is suppressed and `load_err_o` is set. Bytes are still consumed, so the stream stays aligned.
  - `words_loaded_o` counts only words actually written, saturating at 2**ADDR_W.
- `load_start_i`:
  - Sampled in IDLE, RUN or ERR.
  - Next state is LEN_HI; `cpu_rst_o` goes to 1 on the same edge; `load_err_o` and `words_loaded_o` clear.
  - Ignored while the loader is active.
- `cpu_rst_o` is registered: 1 in every state except RUN, 0 in RUN. It is low starting the cycle after the final byte of the stream is accepted.
- `load_busy_o` = 1 in LEN_HI, LEN_LO, DATA and CSUM.
- Fetch path (combinational):
  - `rom_data_o` = `mem[rom_addr_i[ADDR_W+1:2]]` only when `rom_ce_i`=1, state==RUN and `rom_addr_i[31:ADDR_W+2]`==0.
  - Otherwise `rom_data_o` = 32'h0, which is a MIPS nop.
  - `rom_addr_i[1:0]` is ignored.
- Simultaneous events:
  - A write during RUN cannot occur.
  - A `load_start_i` pulse in the same cycle as a CPU fetch: the fetch still returns the old word that cycle, and zero from the next cycle.

Optional Feature:
- Macro `INST_ROM_CHECKSUM_EN`.
- Enabled:
  - After the last data byte the FSM enters CSUM and accepts one extra byte.
  - That byte must equal the XOR of all length and data bytes.
  - Match: go to RUN.
  - Mismatch: set `load_err_o` and go to ERR. ERR keeps `cpu_rst_o`=1 and `rom_data_o`=0, and exits only via `load_start_i` or `rst`.
- Disabled: the CSUM and ERR states do not exist; the stream ends after the data bytes.

Test Plan:
- Reset boot, BOOT_ON_RESET=1: stream 00 02 34 01 00 01 34 02 00 02 → `cpu_rst_o` drops one cycle after the last byte. Fetch addr 0x0 → 0x34010001; addr 0x4 → 0x34020002; `words_loaded_o`=2.
- Fetch gating: in RUN, `rom_ce_i`=0 at addr 0x0 → `rom_data_o`=0. Addr 0x1000 with ADDR_W=10 → 0. Addr 0x6 → word 1.
- N=0 stream 00 00 → RUN after 2 bytes; `words_loaded_o`=0; no memory writes.
- Overflow, ADDR_W=2: N=5 with 20 data bytes → 4 words written, `load_err_o`=1, `words_loaded_o`=4, ends in RUN.
- Reload and backpressure: in RUN, pulse `load_start_i` → `cpu_rst_o`=1 next cycle, fetches return 0. Toggle `load_valid_i` 1/0 during the stream → only handshaken bytes are taken; the result matches the unstalled load.
- Checksum, `INST_ROM_CHECKSUM_EN`: stream 00 01 AA BB CC DD with checksum byte 00^01^AA^BB^CC^DD = 0x01 → RUN. Same stream with checksum 0x02 → ERR, `load_err_o`=1, `cpu_rst_o` stays 1. Assert `rst` mid-DATA → immediate return to the reset state.

Source files
------------

// File: rtl/inst_rom_boot.sv
// Instruction ROM for the CPU fetch port, filled by a byte-stream boot loader
// that holds the core in reset until the image is in place. Optional trailing
// XOR checksum byte is enabled by defining INST_ROM_CHECKSUM_EN.
module inst_rom_boot #(
    parameter int ADDR_W        = 10,
    parameter bit BOOT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    output logic              cpu_rst_o,
    input  logic              load_start_i,
    input  logic              load_valid_i,
    input  logic [7:0]        load_byte_i,
    output logic              load_ready_o,
    output logic              load_busy_o,
    output logic              load_err_o,
    output logic [ADDR_W:0]   words_loaded_o
);

    localparam int          DEPTH   = 1 << ADDR_W;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
`ifdef INST_ROM_CHECKSUM_EN
        ST_CSUM,
        ST_ERR,
`endif
        ST_RUN
    } state_t;

    localparam state_t RESET_STATE = BOOT_ON_RESET ? ST_LEN_HI : ST_IDLE;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [16:0]         word_idx_q, word_idx_d;
    logic [23:0]         word_buf_q, word_buf_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                err_q, err_d;
    logic [ADDR_W:0]     words_q, words_d;
`ifdef INST_ROM_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                ready;
    logic                byte_fire;
    logic                start_ok;
    logic                last_word;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [31:0]         mem_wdata;
    logic                rd_hit;
    logic                unused_addr_bits;

    logic [31:0] mem [DEPTH];

    always_comb begin
        ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) || (state_q == ST_DATA);
`ifdef INST_ROM_CHECKSUM_EN
        ready = ready || (state_q == ST_CSUM);
`endif
    end

    assign byte_fire = load_valid_i && ready;
    assign last_word = (word_idx_q + 17'd1) == {1'b0, len_q};

    always_comb begin
        start_ok = load_start_i && ((state_q == ST_IDLE) || (state_q == ST_RUN));
`ifdef INST_ROM_CHECKSUM_EN
        start_ok = start_ok || (load_start_i && (state_q == ST_ERR));
`endif
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        word_buf_d = word_buf_q;
        err_d      = err_q;
        words_d    = words_q;
`ifdef INST_ROM_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        mem_we     = 1'b0;
        mem_waddr  = word_idx_q[ADDR_W-1:0];
        mem_wdata  = {word_buf_q, load_byte_i};

        if (start_ok) begin
            state_d    = ST_LEN_HI;
            len_d      = 16'd0;
            byte_cnt_d = 2'd0;
            word_idx_d = 17'd0;
            err_d      = 1'b0;
            words_d    = '0;
`ifdef INST_ROM_CHECKSUM_EN
            csum_d     = 8'd0;
`endif
        end else if (byte_fire) begin
`ifdef INST_ROM_CHECKSUM_EN
            if (state_q != ST_CSUM) begin
                csum_d = csum_q ^ load_byte_i;
            end
`endif
            case (state_q)
                ST_LEN_HI: begin
                    len_d[15:8] = load_byte_i;
                    state_d     = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    len_d[7:0] = load_byte_i;
                    if ({len_q[15:8], load_byte_i} == 16'd0) begin
`ifdef INST_ROM_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_RUN;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q != 2'd3) begin
                        word_buf_d = {word_buf_q[15:0], load_byte_i};
                    end else begin
                        // Words beyond the array are dropped but still counted
                        // against N so the stream ends where the sender expects.
                        if (word_idx_q < DEPTH_W) begin
                            mem_we  = 1'b1;
                            words_d = words_q + 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        word_idx_d = word_idx_q + 17'd1;
                        if (last_word) begin
`ifdef INST_ROM_CHECKSUM_EN
                            state_d = ST_CSUM;
`else
                            state_d = ST_RUN;
`endif
                        end
                    end
                end
`ifdef INST_ROM_CHECKSUM_EN
                ST_CSUM: begin
                    if (load_byte_i == csum_q) begin
                        state_d = ST_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
`endif
                default: ;
            endcase
        end

        cpu_rst_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            len_q      <= 16'd0;
            byte_cnt_q <= 2'd0;
            word_idx_q <= 17'd0;
            word_buf_q <= 24'd0;
            cpu_rst_q  <= 1'b1;
            err_q      <= 1'b0;
            words_q    <= '0;
`ifdef INST_ROM_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            word_buf_q <= word_buf_d;
            cpu_rst_q  <= cpu_rst_d;
            err_q      <= err_d;
            words_q    <= words_d;
`ifdef INST_ROM_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Image storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_hit = rom_ce_i && (state_q == ST_RUN) && (rom_addr_i[31:ADDR_W+2] == '0);
    assign rom_data_o = rd_hit ? mem[rom_addr_i[ADDR_W+1:2]] : 32'h0;
    assign unused_addr_bits = ^rom_addr_i[1:0];

    assign cpu_rst_o      = cpu_rst_q;
    assign load_ready_o   = ready;
    assign load_busy_o    = ready;
    assign load_err_o     = err_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_inst_rom_boot.sv
// Scoreboard bench for inst_rom_boot (ADDR_W=2, boot on reset); stimulus queues
// expected snapshots, a negedge monitor pops and compares them.
module tb_inst_rom_boot;

    localparam int ADDR_W = 2;
`ifdef INST_ROM_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              rom_ce;
    logic [31:0]       rom_addr;
    logic [31:0]       rom_data;
    logic              cpu_rst;
    logic              load_start;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_ready;
    logic              load_busy;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    inst_rom_boot #(.ADDR_W(ADDR_W), .BOOT_ON_RESET(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_ce_i       (rom_ce),
        .rom_addr_i     (rom_addr),
        .rom_data_o     (rom_data),
        .cpu_rst_o      (cpu_rst),
        .load_start_i   (load_start),
        .load_valid_i   (load_valid),
        .load_byte_i    (load_byte),
        .load_ready_o   (load_ready),
        .load_busy_o    (load_busy),
        .load_err_o     (load_err),
        .words_loaded_o (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        crst;
        logic        err;
        logic [31:0] words;
        logic        ready;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] stream_q[$];
    logic       chk_req = 1'b0;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic cmp(input string name, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", name, fld, act, exp);
        end
    endtask

    // Monitor: one popped snapshot per requested sample point.
    always @(negedge clk) begin
        if (chk_req) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard: got sample with empty queue, expected an entry");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                cmp(e.name, "rom_data", rom_data, e.data);
                cmp(e.name, "cpu_rst", {31'd0, cpu_rst}, {31'd0, e.crst});
                cmp(e.name, "load_err", {31'd0, load_err}, {31'd0, e.err});
                cmp(e.name, "words_loaded", {29'd0, words_loaded}, e.words);
                cmp(e.name, "load_ready", {31'd0, load_ready}, {31'd0, e.ready});
                cmp(e.name, "load_busy", {31'd0, load_busy}, {31'd0, e.ready});
                $display("[TB] check %s addr=%h data=%h cpu_rst=%0b err=%0b words=%0d",
                         e.name, rom_addr, rom_data, cpu_rst, load_err, words_loaded);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] d, input logic cr, input logic er,
                       input logic [31:0] w, input logic rdy);
        exp_t e;
        e.name = name; e.data = d; e.crst = cr; e.err = er; e.words = w; e.ready = rdy;
        exp_q.push_back(e);
        chk_req = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        chk_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        load_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        load_valid = 1'b1;
        load_byte  = b;
        n = 0;
        @(negedge clk);
        while (!load_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!load_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_byte timeout: load_ready=0, expected 1 for byte %h", b);
        end
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic add_csum();
        logic [7:0] x;
        x = 8'h00;
        foreach (stream_q[i]) x ^= stream_q[i];
        if (CS) stream_q.push_back(x);
    endtask

    task automatic send_stream(input int gap);
        foreach (stream_q[i]) send_byte(stream_q[i], gap);
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rom_ce = 1'b1; rom_addr = 32'h0;
        load_start = 1'b0; load_valid = 1'b0; load_byte = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 32'h0, 1'b1, 1'b0, 0, 1'b1);
        rst = 1'b0;

        // Boot straight out of reset; cpu_rst must stay high until the last byte.
        stream_q = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h01, 8'h34, 8'h02, 8'h00, 8'h02};
        add_csum();
        for (int i = 0; i < stream_q.size() - 1; i++) send_byte(stream_q[i], 0);
        chk("boot_pre_last", 32'h0, 1'b1, 1'b0, CS ? 2 : 1, 1'b1);
        send_byte(stream_q[stream_q.size() - 1], 0);
        chk("boot_run_w0", 32'h34010001, 1'b0, 1'b0, 2, 1'b0);
        rom_addr = 32'h4;
        chk("boot_run_w1", 32'h34020002, 1'b0, 1'b0, 2, 1'b0);

        // Fetch gating.
        rom_ce = 1'b0; rom_addr = 32'h0;
        chk("ce_low", 32'h0, 1'b0, 1'b0, 2, 1'b0);
        rom_ce = 1'b1; rom_addr = 32'h10;
        chk("addr_oob", 32'h0, 1'b0, 1'b0, 2, 1'b0);
        rom_addr = 32'h1000;
        chk("addr_oob_hi", 32'h0, 1'b0, 1'b0, 2, 1'b0);
        rom_addr = 32'h6;
        chk("addr_6", 32'h34020002, 1'b0, 1'b0, 2, 1'b0);

        // Start coincident with a fetch: old word this cycle, nop afterwards.
        rom_addr = 32'h0;
        load_start = 1'b1;
        chk("start_same_cycle", 32'h34010001, 1'b0, 1'b0, 2, 1'b0);
        load_start = 1'b0;
        chk("after_start", 32'h0, 1'b1, 1'b0, 0, 1'b1);

        // Empty image.
        stream_q = '{8'h00, 8'h00};
        add_csum();
        send_stream(0);
        chk("n0_run", 32'h34010001, 1'b0, 1'b0, 0, 1'b0);

        // Overflow: five words into a four-word array.
        pulse_start();
        stream_q = '{8'h00, 8'h05};
        for (int w = 1; w <= 5; w++)
            for (int k = 0; k < 4; k++) stream_q.push_back(8'(8'h11 * w));
        add_csum();
        send_stream(1);
        rom_addr = 32'hC;
        chk("ovf_word3", 32'h44444444, 1'b0, 1'b1, 4, 1'b0);
        rom_addr = 32'h0;
        chk("ovf_word0", 32'h11111111, 1'b0, 1'b1, 4, 1'b0);

        // Reload with a stalling sender.
        pulse_start();
        chk("reload_clear", 32'h0, 1'b1, 1'b0, 0, 1'b1);
        stream_q = '{8'h00, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
        add_csum();
        send_stream(2);
        chk("stall_w0", 32'hA1B2C3D4, 1'b0, 1'b0, 2, 1'b0);
        rom_addr = 32'h4;
        chk("stall_w1", 32'h0BADF00D, 1'b0, 1'b0, 2, 1'b0);
        rom_addr = 32'h8;
        chk("stall_w2_kept", 32'h33333333, 1'b0, 1'b0, 2, 1'b0);

        // Reset in the middle of a data word.
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h34, 0);
        rst = 1'b1;
        chk("rst_mid_data", 32'h0, 1'b1, 1'b0, 0, 1'b1);
        rst = 1'b0;
        stream_q = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        add_csum();
        send_stream(0);
        rom_addr = 32'h0;
        chk("after_rst_w0", 32'hCAFEBABE, 1'b0, 1'b0, 1, 1'b0);

`ifdef INST_ROM_CHECKSUM_EN
        pulse_start();
        stream_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
        send_stream(0);
        chk("cs_good", 32'hAABBCCDD, 1'b0, 1'b0, 1, 1'b0);
        pulse_start();
        stream_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h02};
        send_stream(0);
        chk("cs_bad", 32'h0, 1'b1, 1'b1, 1, 1'b0);
        chk("cs_err_hold", 32'h0, 1'b1, 1'b1, 1, 1'b0);
        pulse_start();
        chk("cs_err_exit", 32'h0, 1'b1, 1'b0, 0, 1'b1);
`endif

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
